// File: rtl/axi_mem_responder.sv
// AXI4 slave memory with independent read/write FSMs over a dual-ported word array.
// Optional build macro AXI_MEM_RESP_CHECK_EN enables SLVERR detection and out-of-range suppression.
module axi_mem_responder #(
    parameter int                         AXI_WIDTH_SID  = 6,
    parameter int                         AXI_WIDTH_ADDR = 32,
    parameter int                         AXI_WIDTH_DATA = 32,
    parameter int                         AXI_WIDTH_STRB = 4,
    parameter logic [AXI_WIDTH_ADDR-1:0]  MEM_BASE       = 32'h0000_0000,
    parameter int                         MEM_SIZE       = 64*1024
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic [AXI_WIDTH_SID-1:0]  s_axi_awid,
    input  logic [AXI_WIDTH_ADDR-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_WIDTH_DATA-1:0] s_axi_wdata,
    input  logic [AXI_WIDTH_STRB-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [AXI_WIDTH_SID-1:0]  s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_WIDTH_SID-1:0]  s_axi_arid,
    input  logic [AXI_WIDTH_ADDR-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_WIDTH_SID-1:0]  s_axi_rid,
    output logic [AXI_WIDTH_DATA-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int              AW        = AXI_WIDTH_ADDR;
    localparam int              MEM_WORDS = MEM_SIZE / 4;
    localparam int              IDX_W     = $clog2(MEM_WORDS);
    localparam logic [AW-1:0]   SIZE_A    = AW'(MEM_SIZE);
`ifdef AXI_MEM_RESP_CHECK_EN
    localparam logic            CHECK_EN  = 1'b1;
`else
    localparam logic            CHECK_EN  = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] step;
        logic [AW-1:0] mask;
        step = AW'(1'b1) << size;
        mask = ((AW'(len) + AW'(1'b1)) * step) - AW'(1'b1);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | ((addr + step) & mask);
            default: next_addr = addr + step;
        endcase
    endfunction

    // Without checking every address aliases into the array, so it is always "in range".
    function automatic logic in_range(input logic [AW-1:0] addr);
        in_range = !CHECK_EN || ((addr - MEM_BASE) < SIZE_A);
    endfunction

    function automatic logic burst_err(input logic [AW-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic wrap_bad;
        wrap_bad  = (burst == 2'b10) &&
                    !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        burst_err = CHECK_EN && (!in_range(addr) || (size > 3'd2) || (burst == 2'b11) || wrap_bad);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] addr);
        word_idx = IDX_W'((addr - MEM_BASE) >> 2);
    endfunction

    logic [AXI_WIDTH_DATA-1:0] mem_r [0:MEM_WORDS-1];

    w_state_t                  w_state_r;
    logic                      awready_r, wready_r, bvalid_r, werr_r;
    logic [1:0]                bresp_r;
    logic [AXI_WIDTH_SID-1:0]  bid_r;
    logic [AW-1:0]             waddr_r;
    logic [7:0]                wlen_r, wcnt_r;
    logic [2:0]                wsize_r;
    logic [1:0]                wburst_r;
    logic                      wen_s, werr_next_s;
    logic [IDX_W-1:0]          w_idx_s;

    r_state_t                  r_state_r;
    logic                      arready_r, rvalid_r, rlast_r, rerr_r;
    logic [1:0]                rresp_r;
    logic [AXI_WIDTH_SID-1:0]  rid_r;
    logic [AXI_WIDTH_DATA-1:0] rdata_r;
    logic [AW-1:0]             raddr_r;
    logic [7:0]                rlen_r, rcnt_r;
    logic [2:0]                rsize_r;
    logic [1:0]                rburst_r;
    logic [AW-1:0]             rd_addr_s;
    logic [AXI_WIDTH_DATA-1:0] rd_word_s;
    logic                      rd_berr_s;
    logic [1:0]                rd_resp_s;

    // Write-beat decode: enable, target word and accumulated error for the current beat.
    always_comb begin
        wen_s       = (w_state_r == W_DATA) && s_axi_wvalid && wready_r && in_range(waddr_r);
        w_idx_s     = word_idx(waddr_r);
        werr_next_s = werr_r || !in_range(waddr_r) ||
                      (CHECK_EN && (s_axi_wlast != (wcnt_r == wlen_r)));
    end

    // Write channel FSM: AW latch, data beats, single B response.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            bid_r     <= '0;
            werr_r    <= 1'b0;
            waddr_r   <= '0;
            wlen_r    <= 8'd0;
            wcnt_r    <= 8'd0;
            wsize_r   <= 3'd0;
            wburst_r  <= 2'b00;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (s_axi_awvalid && awready_r) begin
                        bid_r     <= s_axi_awid;
                        waddr_r   <= s_axi_awaddr;
                        wlen_r    <= s_axi_awlen;
                        wsize_r   <= s_axi_awsize;
                        wburst_r  <= s_axi_awburst;
                        werr_r    <= burst_err(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
                        wcnt_r    <= 8'd0;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        w_state_r <= W_DATA;
                    end else begin
                        awready_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid && wready_r) begin
                        waddr_r <= next_addr(waddr_r, wlen_r, wsize_r, wburst_r);
                        wcnt_r  <= wcnt_r + 8'd1;
                        werr_r  <= werr_next_s;
                        // The beat count, not wlast, ends the burst.
                        if (wcnt_r == wlen_r) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= werr_next_s ? 2'b10 : 2'b00;
                            w_state_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane array write; the array content deliberately survives reset.
    always_ff @(posedge axi_aclk) begin
        if (wen_s) begin
            for (int b = 0; b < AXI_WIDTH_STRB; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_r[w_idx_s][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read port: start address while idle, otherwise the next beat's address.
    always_comb begin
        rd_addr_s = (r_state_r == R_IDLE) ? s_axi_araddr : raddr_r;
        rd_word_s = in_range(rd_addr_s) ? mem_r[word_idx(rd_addr_s)] : {AXI_WIDTH_DATA{1'b0}};
        rd_berr_s = (r_state_r == R_IDLE) ?
                    burst_err(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst) : rerr_r;
        rd_resp_s = (rd_berr_s || !in_range(rd_addr_s)) ? 2'b10 : 2'b00;
    end

    // Read channel FSM: AR loads beat 0, each R handshake loads the next beat.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= 2'b00;
            rid_r     <= '0;
            rdata_r   <= '0;
            rerr_r    <= 1'b0;
            raddr_r   <= '0;
            rlen_r    <= 8'd0;
            rcnt_r    <= 8'd0;
            rsize_r   <= 3'd0;
            rburst_r  <= 2'b00;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (s_axi_arvalid && arready_r) begin
                        rid_r     <= s_axi_arid;
                        rlen_r    <= s_axi_arlen;
                        rsize_r   <= s_axi_arsize;
                        rburst_r  <= s_axi_arburst;
                        rerr_r    <= rd_berr_s;
                        raddr_r   <= next_addr(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
                        rcnt_r    <= 8'd0;
                        rdata_r   <= rd_word_s;
                        rresp_r   <= rd_resp_s;
                        rlast_r   <= (s_axi_arlen == 8'd0);
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        r_state_r <= R_DATA;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            rdata_r <= rd_word_s;
                            rresp_r <= rd_resp_s;
                            raddr_r <= next_addr(raddr_r, rlen_r, rsize_r, rburst_r);
                            rcnt_r  <= rcnt_r + 8'd1;
                            rlast_r <= ((rcnt_r + 8'd1) == rlen_r);
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_bid     = bid_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rlast   = rlast_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rid     = rid_r;
    assign s_axi_rdata   = rdata_r;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (default build, or with AXI_MEM_RESP_CHECK_EN).
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int passes = 0;

    logic [31:0] wbuf  [0:255];
    logic [3:0]  sbuf  [0:255];
    logic [31:0] rbuf  [0:255];
    logic [1:0]  rrbuf [0:255];
    logic        rlbuf [0:255];
    logic [5:0]  ridbuf[0:255];
    int          rcount;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [5:0] id, input int bdelay,
                            output logic [1:0] resp, output logic [5:0] bid_o, output int hold_bad);
        int   n;
        logic hs;
        hold_bad = 0; resp = 2'b11; bid_o = 6'd0;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        n = 0;
        do begin hs = awready; tick(); n++; end while (!hs && n < 50);
        awvalid = 1'b0;
        if (!hs) begin
            checks++; $display("FAIL aw_timeout: awready never high, required 1"); return;
        end
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == int'(len)); wvalid = 1'b1;
            n = 0;
            do begin hs = wready; tick(); n++; end while (!hs && n < 50);
            if (!hs) begin
                wvalid = 1'b0; checks++;
                $display("FAIL w_timeout: beat %0d not accepted, required accept", i); return;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (!bvalid) begin
            checks++; $display("FAIL b_timeout: bvalid never high, required 1"); return;
        end
        for (int k = 0; k < bdelay; k++) begin
            if (!bvalid || awready) hold_bad++;
            tick();
        end
        resp = bresp; bid_o = bid; bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [5:0] id, input logic toggle,
                           output logic first_valid, output int stall_bad);
        int          n;
        logic        hs, rr, hv, hl;
        logic [31:0] hd;
        stall_bad = 0; first_valid = 1'b0; rcount = 0;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        n = 0;
        do begin hs = arready; tick(); n++; end while (!hs && n < 50);
        arvalid = 1'b0;
        if (!hs) begin
            checks++; $display("FAIL ar_timeout: arready never high, required 1"); return;
        end
        first_valid = rvalid;
        n = 0;
        while (rcount <= int'(len) && n < 2000) begin
            rr = toggle ? ((n % 2) == 0) : 1'b1;
            rready = rr;
            if (rvalid && rr) begin
                rbuf[rcount] = rdata; rrbuf[rcount] = rresp;
                rlbuf[rcount] = rlast; ridbuf[rcount] = rid;
                rcount++;
            end
            hv = rvalid; hd = rdata; hl = rlast;
            tick(); n++;
            if (hv && !rr && (!rvalid || rdata !== hd || rlast !== hl)) stall_bad++;
        end
        rready = 1'b0;
        if (rcount <= int'(len)) begin
            checks++; $display("FAIL r_timeout: got %0d beats, required %0d", rcount, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0)
            $display("FAIL reset_ctrl: got %b, required 000000", {awready, wready, bvalid, arready, rvalid, rlast});
        else passes++;
        checks++;
        if ({bresp, rresp, bid, rid, rdata} !== 48'd0)
            $display("FAIL reset_data: got %h, required 0", {bresp, rresp, bid, rid, rdata});
        else passes++;
        rst_n = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b0) $display("FAIL release_pre_edge: awready %b, required 0", awready);
        else passes++;
        tick();
        checks++;
        if ({awready, arready} !== 2'b11)
            $display("FAIL release_ready: got %b, required 11", {awready, arready});
        else passes++;
    endtask

    task automatic test_incr();
        logic [1:0] r; logic [5:0] b; int hb, sb; logic fv;
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h1111_1111 * (i + 1); sbuf[i] = 4'hF; end
        do_write(32'h100, 8'd3, 2'b01, 6'h2A, 0, r, b, hb);
        checks++;
        if ({r, b} !== {2'b00, 6'h2A}) $display("FAIL incr_b: resp/id %b/%h, required 00/2a", r, b);
        else passes++;
        checks++;
        if (awready !== 1'b1) $display("FAIL incr_awready_back: got %b, required 1", awready);
        else passes++;
        do_read(32'h100, 8'd3, 2'b01, 6'h15, 1'b0, fv, sb);
        checks++;
        if (fv !== 1'b1) $display("FAIL incr_r_latency: rvalid %b after AR, required 1", fv);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rbuf[i], rlbuf[i], rrbuf[i], ridbuf[i]} !== {32'h1111_1111 * (i + 1), (i == 3), 2'b00, 6'h15})
                $display("FAIL incr_beat%0d: data/last/resp/id %h/%b/%b/%h, required %h/%b/00/15",
                         i, rbuf[i], rlbuf[i], rrbuf[i], ridbuf[i], 32'h1111_1111 * (i + 1), (i == 3));
            else passes++;
        end
        checks++;
        if ({rvalid, arready} !== 2'b01)
            $display("FAIL incr_r_end: rvalid/arready %b, required 01", {rvalid, arready});
        else passes++;
    endtask

    task automatic test_wrap();
        logic [1:0] r; logic [5:0] b; int hb, sb; logic fv;
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'(i * 4); sbuf[i] = 4'hF; end
        do_write(32'h0, 8'd7, 2'b01, 6'h01, 0, r, b, hb);
        do_read(32'h18, 8'd7, 2'b10, 6'h02, 1'b0, fv, sb);
        for (int i = 0; i < 8; i++) begin
            exp = (32'h18 + 32'(i * 4)) & 32'h1F;
            checks++;
            if ({rbuf[i], rlbuf[i]} !== {exp, (i == 7)})
                $display("FAIL wrap_beat%0d: data/last %h/%b, required %h/%b", i, rbuf[i], rlbuf[i], exp, (i == 7));
            else passes++;
        end
    endtask

    task automatic test_strobes();
        logic [1:0] r; logic [5:0] b; int hb, sb; logic fv;
        wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'hF;
        do_write(32'h200, 8'd0, 2'b01, 6'h03, 0, r, b, hb);
        wbuf[0] = 32'h0000_0011; sbuf[0] = 4'h1;
        do_write(32'h200, 8'd0, 2'b01, 6'h03, 0, r, b, hb);
        do_read(32'h200, 8'd0, 2'b01, 6'h03, 1'b0, fv, sb);
        checks++;
        if (rbuf[0] !== 32'hAABB_CC11) $display("FAIL strb_lane0: got %h, required aabbcc11", rbuf[0]);
        else passes++;
        wbuf[0] = 32'h9988_7766; sbuf[0] = 4'b1010;
        do_write(32'h200, 8'd0, 2'b01, 6'h03, 0, r, b, hb);
        do_read(32'h200, 8'd2, 2'b00, 6'h03, 1'b0, fv, sb);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rbuf[i] !== 32'h99BB_7711)
                $display("FAIL strb_fixed_beat%0d: got %h, required 99bb7711", i, rbuf[i]);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] r; logic [5:0] b; int hb, sb; logic fv;
        for (int i = 0; i < 16; i++) begin wbuf[i] = 32'hC0DE_0000 + 32'(i); sbuf[i] = 4'hF; end
        do_write(32'h400, 8'd15, 2'b01, 6'h07, 5, r, b, hb);
        checks++;
        if (hb != 0) $display("FAIL b_hold: %0d bad cycles, required 0", hb);
        else passes++;
        checks++;
        if ({r, b} !== {2'b00, 6'h07}) $display("FAIL b_hold_resp: resp/id %b/%h, required 00/07", r, b);
        else passes++;
        do_read(32'h400, 8'd15, 2'b01, 6'h08, 1'b1, fv, sb);
        checks++;
        if (sb != 0) $display("FAIL r_stall_stable: %0d unstable cycles, required 0", sb);
        else passes++;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rbuf[i], rlbuf[i]} !== {32'hC0DE_0000 + 32'(i), (i == 15)})
                $display("FAIL bp_beat%0d: data/last %h/%b, required %h/%b",
                         i, rbuf[i], rlbuf[i], 32'hC0DE_0000 + 32'(i), (i == 15));
            else passes++;
        end
    endtask

    task automatic test_error_path();
        int sb; logic fv;
        logic [31:0] e0, e1; logic [1:0] er;
`ifdef AXI_MEM_RESP_CHECK_EN
        e0 = 32'h0; e1 = 32'h0; er = 2'b10;
`else
        e0 = 32'h0; e1 = 32'h4; er = 2'b00;
`endif
        do_read(32'h0001_0000, 8'd1, 2'b01, 6'h09, 1'b0, fv, sb);
        checks++;
        if ({rbuf[0], rrbuf[0], rbuf[1], rrbuf[1], rlbuf[1]} !== {e0, er, e1, er, 1'b1})
            $display("FAIL err_path: %h/%b %h/%b, required %h/%b %h/%b",
                     rbuf[0], rrbuf[0], rbuf[1], rrbuf[1], e0, er, e1, er);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; logic [5:0] b; int hb, sb, n; logic fv, hs;
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hDEAD_0000 + 32'(i); sbuf[i] = 4'hF; end
        do_write(32'h300, 8'd7, 2'b01, 6'h0A, 0, r, b, hb);
        awid = 6'h0B; awaddr = 32'h300; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        n = 0;
        do begin hs = awready; tick(); n++; end while (!hs && n < 50);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'hBEEF_0000 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            n = 0;
            do begin hs = wready; tick(); n++; end while (!hs && n < 50);
        end
        wdata = 32'hBEEF_0002;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0)
            $display("FAIL midreset_async: got %b, required 000000", {awready, wready, bvalid, arready, rvalid, rlast});
        else passes++;
        wvalid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (awready !== 1'b1) $display("FAIL midreset_awready: got %b, required 1", awready);
        else passes++;
        do_read(32'h300, 8'd3, 2'b01, 6'h0C, 1'b0, fv, sb);
        checks++;
        if ({rbuf[0], rbuf[1], rbuf[2], rbuf[3]} !==
            {32'hBEEF_0000, 32'hBEEF_0001, 32'hDEAD_0002, 32'hDEAD_0003})
            $display("FAIL midreset_words: %h %h %h %h, required beef0000 beef0001 dead0002 dead0003",
                     rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
        else passes++;
    endtask

    initial begin
        rst_n = 1'b0;
        awid = 6'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'b00; awvalid = 1'b0;
        wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 6'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'b00; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_incr();
        test_wrap();
        test_strobes();
        test_backpressure();
        test_error_path();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
